// File: rtl/flex_rx_pkg.sv
// Shared types and helpers for the flexible receive deserializer.
package flex_rx_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Bit counter must hold values 0..num_bits inclusive.
    function automatic int count_width(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/flex_stp_sr_sync.sv
// Serial-to-parallel shift core with synchronous reset and set-to-ones.
// next_value is exposed so the parent can capture a word on its final sampling edge.
module flex_stp_sr_sync #(
    parameter int NUM_BITS  = 8,
    parameter int SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_ones,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic [NUM_BITS-1:0] next_value
);

    logic [NUM_BITS-1:0] base;

    // set_ones clears first, so a coincident shift lands on an all-ones register.
    always_comb begin
        base       = set_ones ? '1 : parallel_out;
        next_value = base;
        if (shift_enable) begin
            if (SHIFT_MSB != 0) begin
                next_value = {base[NUM_BITS-2:0], serial_in};
            end else begin
                next_value = {serial_in, base[NUM_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parallel_out <= '1;
        end else begin
            parallel_out <= next_value;
        end
    end

endmodule

// File: rtl/flex_rx_deserializer.sv
// Parametrised receive deserializer: shift core, bit counter, optional parity
// check and a valid/ready holding register with sticky overrun detection.
module flex_rx_deserializer #(
    parameter int NUM_BITS   = 8,
    parameter int SHIFT_MSB  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                shift_enable,
    input  logic                frame_start,
    input  logic                data_ready,
    input  logic                clear_errors,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_valid,
    output logic                parity_error,
    output logic                overrun_error,
    output logic                busy
);

    import flex_rx_pkg::*;

    localparam int             CW        = count_width(NUM_BITS);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(NUM_BITS - 1);
    localparam logic           ODD_SENSE = (PARITY_ODD != 0) ? flex_rx_pkg::PARITY_ODD
                                                             : flex_rx_pkg::PARITY_EVEN;

    rx_state_t           state, state_next, eff_state;
    logic [CW-1:0]       count, count_next, eff_count;
    logic [NUM_BITS-1:0] sr_q, sr_next, commit_word;
    logic                sr_shift, commit, commit_perr;

    // Data bits only shift while collecting; the parity bit never enters the register.
    assign sr_shift = shift_enable && (frame_start || (state == COLLECT));

    flex_stp_sr_sync #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .set_ones     (frame_start),
        .shift_enable (sr_shift),
        .serial_in    (serial_in),
        .parallel_out (sr_q),
        .next_value   (sr_next)
    );

    always_comb begin
        eff_state   = frame_start ? COLLECT : state;
        eff_count   = frame_start ? '0 : count;
        state_next  = eff_state;
        count_next  = eff_count;
        commit      = 1'b0;
        commit_word = sr_next;
        commit_perr = 1'b0;
        if (shift_enable) begin
            if (eff_state == COLLECT) begin
                if (eff_count == LAST_BIT) begin
                    count_next = '0;
                    if (PARITY_EN != 0) begin
                        state_next = PARITY;
                    end else begin
                        commit = 1'b1;
                    end
                end else begin
                    count_next = eff_count + CW'(1);
                end
            end else begin
                commit      = 1'b1;
                commit_word = sr_q;
                commit_perr = (serial_in != ((^sr_q) ^ ODD_SENSE));
                state_next  = COLLECT;
            end
        end
    end

    // A commit always wins over consumption; overrun only when the held word is not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            count         <= '0;
            rx_data       <= '1;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (commit) begin
                rx_data      <= commit_word;
                parity_error <= commit_perr;
                data_valid   <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (commit && data_valid && !data_ready) begin
                overrun_error <= 1'b1;
            end else if (clear_errors) begin
                overrun_error <= 1'b0;
            end
        end
    end

    assign busy = (count != '0) || (state == PARITY);

endmodule

// File: doc/flex_rx_deserializer.md
Name: flex_rx_deserializer

Overview:
Parametrised serial-to-parallel receive block, the successor to the fixed 8-bit receive shift register. Generalises word width and shift direction, and adds:
- a bit counter with word-complete detection;
- optional parity bit check;
- a holding register with a valid/ready handshake and overrun detection.
It sits between the bit-timing/start-bit logic (which drives shift_enable and frame_start) and the packet/FIFO consumer.

Parameters:
NUM_BITS, 8, data bits per word (2..32)
SHIFT_MSB, 0, 0 = LSB-first (new bit enters at bit NUM_BITS-1, register shifts right); 1 = MSB-first (new bit enters at bit 0, register shifts left)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  serial data bit, sampled when shift_enable=1
shift_enable  input  1  one-cycle strobe: accept serial_in this edge
frame_start  input  1  one-cycle strobe: restart word collection
data_ready  input  1  consumer accepts the held word
clear_errors  input  1  clears the sticky overrun_error
rx_data  output  NUM_BITS  held received word
data_valid  output  1  rx_data holds an unconsumed word
parity_error  output  1  parity status of the held word
overrun_error  output  1  sticky: an unconsumed word was overwritten
busy  output  1  word collection in progress

Behaviour:
- Reset (rst=1 at an edge):
  - shift register all ones; rx_data all ones;
  - bit counter 0; state COLLECT;
  - data_valid, parity_error, overrun_error, busy all 0.
  - rst overrides every other input, including mid-word.
- States:
  - COLLECT: accepting data bits.
  - PARITY: waiting for the parity bit; only reachable when PARITY_EN=1.
- Counter: width $clog2(NUM_BITS+1). busy = (count != 0) || (state == PARITY).
- COLLECT, shift_enable=1:
  - shift serial_in in per SHIFT_MSB; count++.
  - If count was NUM_BITS-1:
    - PARITY_EN=0: commit the shifted word at this same edge; count -> 0.
    - PARITY_EN=1: go to PARITY; count -> 0.
- PARITY, shift_enable=1:
  - expected parity bit = XOR(data) for even, ~XOR(data) for odd;
  - commit the data word with parity_error = (serial_in != expected); go to COLLECT.
- Commit:
  - rx_data and parity_error load, and data_valid=1, visible the cycle after the final sampling edge (latency 1 clk).
  - With PARITY_EN=0, parity_error stays 0.
- Handshake:
  - A word is consumed at an edge where data_valid && data_ready; data_valid then drops to 0 unless a commit occurs at the same edge.
  - Commit and consume at the same edge: the new word loads, data_valid stays 1, no overrun.
  - Commit while data_valid=1 and data_ready=0: the new word overwrites the held word and overrun_error <= 1.
- overrun_error: sticky until clear_errors or rst. If clear_errors and a new overrun occur at the same edge, the overrun wins and the flag stays 1.
- frame_start=1:
  - shift register all ones, count 0, state COLLECT; holding register and data_valid unaffected.
  - frame_start and shift_enable at the same edge: the clear applies first, then the bit is accepted as the first bit (count -> 1).
- data_ready with data_valid=0: ignored.
- shift_enable=0: all collection state holds.

Decomposition:
- Package flex_rx_pkg:
  - state enum rx_state_t {COLLECT, PARITY};
  - PARITY_EVEN/PARITY_ODD localparams;
  - function for counter width.
- Sub-module flex_stp_sr_sync:
  - NUM_BITS/SHIFT_MSB shift core with synchronous active-high reset plus a synchronous set-to-ones input (driven by frame_start);
  - exposes its next-value bus so the top level can commit at the final sampling edge.
- Counter, FSM, parity and holding register live in the top level.

Test Plan:
- NUM_BITS=8, SHIFT_MSB=0: shift bits 1,0,1,0,0,1,0,1 -> rx_data=0xA5 and data_valid=1 one cycle after the 8th strobe; busy=0.
- NUM_BITS=8, SHIFT_MSB=1: shift the same bit sequence -> rx_data=0xA5.
- PARITY_EN=1, even parity, data 0x03 LSB-first:
  - parity bit 0 -> parity_error=0;
  - repeat with parity bit 1 -> parity_error=1;
  - data_valid only after the 9th strobe.
- Overrun (data_ready=0):
  - receive 0x11 then 0x22 -> rx_data=0x22, overrun_error=1;
  - flag persists after consumption; clear_errors -> 0.
- Commit coincident with data_ready=1 while 0x11 is held -> rx_data=0x22, data_valid stays 1, overrun_error=0.
- Interruptions:
  - frame_start after 4 bits, then 8 bits of 0x3C -> rx_data=0x3C, no partial word;
  - rst asserted mid-word -> all outputs at reset values the next cycle.
